// File: rtl/param_delay_line_pkg.sv
// Shared definitions for the programmable delay line: default sizing,
// the per-stage record layout and the settle-counter width helper.
package param_delay_line_pkg;

    localparam int unsigned DLY_MAX_DEPTH = 16;
    localparam int unsigned DLY_DATA_W    = 8;

    // One register stage: qualifier plus sample
    typedef struct packed {
        logic                  valid;
        logic [DLY_DATA_W-1:0] data;
    } dly_rec_t;

    // Counter must reach MAX_DEPTH inclusive
    function automatic int unsigned settle_cnt_w(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

endpackage

// File: rtl/param_delay_line_dly_stage.sv
// Single register slice of the delay line: captures {valid, data} on an
// enabled edge, clears on flush, holds otherwise.
module dly_stage
    import param_delay_line_pkg::*;
#(
    parameter int unsigned DATA_W = DLY_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    // Stage register: flush beats enable, enable gates the shift
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (flush) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (en) begin
            valid_o <= valid_i;
            data_o  <= data_i;
        end
    end

endmodule

// File: rtl/param_delay_line.sv
// Runtime-selectable delay line. Tap 0 is a combinational pass-through,
// taps 1..MAX_DEPTH are register stages. A settle counter suppresses
// valid_o after a tap switch or flush until the selected tap only holds
// samples captured after that event.
module param_delay_line
    import param_delay_line_pkg::*;
#(
    parameter int unsigned DATA_W    = DLY_DATA_W,
    parameter int unsigned MAX_DEPTH = DLY_MAX_DEPTH,
    parameter int unsigned SEL_W     = 5
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [SEL_W-1:0]  dly_sel,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              settled,
    output logic              sel_err
);

    localparam int unsigned CNT_W = settle_cnt_w(MAX_DEPTH);
    localparam int unsigned CMP_W = (CNT_W > SEL_W) ? CNT_W : SEL_W;

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DEPTH);

    // Index 0 is the live input; index k is the output of stage k
    logic [MAX_DEPTH:0][DATA_W-1:0] st_data;
    logic [MAX_DEPTH:0]             st_valid;

    logic [SEL_W-1:0] d_eff;
    logic [SEL_W-1:0] dly_q;
    logic [CNT_W-1:0] settle_cnt;
    logic             sel_over;
    logic             change;
    logic             valid_raw;
    logic [CMP_W-1:0] cnt_ext;
    logic [CMP_W-1:0] d_ext;

    assign st_data[0]  = data_i;
    assign st_valid[0] = valid_i;

    for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
        dly_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .en        (en),
            .flush     (flush),
            .valid_i   (st_valid[k-1]),
            .data_i    (st_data[k-1]),
            .valid_o   (st_valid[k]),
            .data_o    (st_data[k])
        );
    end

    assign sel_over = (dly_sel > MAX_SEL);
    assign d_eff    = sel_over ? MAX_SEL : dly_sel;
    assign change   = (d_eff != dly_q);
    assign cnt_ext  = CMP_W'(settle_cnt);
    assign d_ext    = CMP_W'(d_eff);

    // Output tap selection; tap 0 is forced low while reset is asserted
    always_comb begin
        data_o    = '0;
        valid_raw = 1'b0;
        settled   = 1'b0;
        if (d_eff == '0) begin
            if (sys_rst_n) begin
                data_o    = data_i;
                valid_raw = valid_i;
                settled   = 1'b1;
            end
        end else begin
            data_o    = st_data[d_eff];
            valid_raw = st_valid[d_eff];
            settled   = sys_rst_n & (cnt_ext >= d_ext) & ~change;
        end
        valid_o = valid_raw & settled;
    end

    // Tap tracking, saturating settle counter and registered range error
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dly_q      <= '0;
            settle_cnt <= '0;
            sel_err    <= 1'b0;
        end else begin
            dly_q   <= d_eff;
            sel_err <= sel_over;
            if (flush || change) begin
                settle_cnt <= '0;
            end else if (en && (settle_cnt < CNT_MAX)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

endmodule
